msrv32_pc_pipe_reg: RTL and testbench

- Parametrised successor to the single program-counter register.
- Holds the fetch PC and adds a boot address, stall hold, flush/redirect with priority, and word alignment with error flagging.
- Carries the PC down a PIPE_DEPTH-deep delay chain with per-stage valid bits, so downstream stages (decode, execute, writeback) each get the PC of the instruction they hold.
- Sits between the PC mux and the instruction-memory address / downstream pipeline registers.

---
 rtl/msrv32_pc_pipe_reg.sv | 105 ++++++++++
 tb/tb_msrv32_pc_pipe_reg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_pc_pipe_reg.sv
// Fetch PC register with boot address, stall/flush priority, word alignment and a delayed-PC chain.
// Optional trace counters are compiled in when MSRV32_PC_TRACE_EN is defined.
module msrv32_pc_pipe_reg #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR  = '0,
  parameter int unsigned     PIPE_DEPTH = 3
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_n_in,
  input  logic [XLEN-1:0]            pc_mux_in,
  input  logic                       stall_in,
  input  logic                       flush_in,
  input  logic [XLEN-1:0]            redirect_addr_in,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN*PIPE_DEPTH-1:0] pc_pipe_out,
  output logic [PIPE_DEPTH-1:0]      pc_valid_out,
`ifdef MSRV32_PC_TRACE_EN
  output logic [15:0]                redirect_cnt_out,
  output logic [XLEN-1:0]            last_redirect_out,
`endif
  output logic                       misalign_err_out
);

  logic [XLEN-1:0]                  pc_q, pc_d;
  logic [PIPE_DEPTH-1:0][XLEN-1:0]  stage_q, stage_d;
  logic [PIPE_DEPTH-1:0]            valid_q, valid_d;
  logic                             err_q, err_d;

  logic [XLEN-1:0] mux_aligned;
  logic [XLEN-1:0] redirect_aligned;

  assign mux_aligned      = {pc_mux_in[XLEN-1:2], 2'b00};
  assign redirect_aligned = {redirect_addr_in[XLEN-1:2], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    stage_d = stage_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (flush_in) begin
      // Stage data is left alone; clearing the valids is enough to kill it.
      pc_d    = redirect_aligned;
      valid_d = '0;
      err_d   = |redirect_addr_in[1:0];
    end else if (!stall_in) begin
      pc_d       = mux_aligned;
      stage_d[0] = pc_q;
      valid_d[0] = 1'b1;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      err_d = |pc_mux_in[1:0];
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      pc_q    <= BOOT_ADDR;
      stage_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_pipe_out      = stage_q;
  assign pc_valid_out     = valid_q;
  assign misalign_err_out = err_q;

`ifdef MSRV32_PC_TRACE_EN
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;
  logic [XLEN-1:0] last_redirect_q, last_redirect_d;

  always_comb begin
    redirect_cnt_d  = redirect_cnt_q;
    last_redirect_d = last_redirect_q;
    if (flush_in) begin
      last_redirect_d = redirect_aligned;
      if (redirect_cnt_q != 16'hFFFF) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      redirect_cnt_q  <= 16'd0;
      last_redirect_q <= BOOT_ADDR;
    end else begin
      redirect_cnt_q  <= redirect_cnt_d;
      last_redirect_q <= last_redirect_d;
    end
  end

  assign redirect_cnt_out  = redirect_cnt_q;
  assign last_redirect_out = last_redirect_q;
`endif

endmodule

// File: tb/tb_msrv32_pc_pipe_reg.sv
// Self-checking bench for msrv32_pc_pipe_reg: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch PC and its delayed copies.
module tb_msrv32_pc_pipe_reg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] BOOT  = 32'h0000_0100;

  logic              clk;
  logic              rst_n;
  logic [XLEN-1:0]   pc_mux;
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   redir;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN*DEPTH-1:0] pipe_out;
  logic [DEPTH-1:0]  valid_out;
  logic              err_out;
`ifdef MSRV32_PC_TRACE_EN
  logic [15:0]       cnt_out;
  logic [XLEN-1:0]   last_out;
`endif

  msrv32_pc_pipe_reg #(
    .XLEN      (XLEN),
    .BOOT_ADDR (BOOT),
    .PIPE_DEPTH(DEPTH)
  ) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .pc_mux_in             (pc_mux),
    .stall_in              (stall),
    .flush_in              (flush),
    .redirect_addr_in      (redir),
    .pc_out                (pc_out),
    .pc_pipe_out           (pipe_out),
    .pc_valid_out          (valid_out),
`ifdef MSRV32_PC_TRACE_EN
    .redirect_cnt_out      (cnt_out),
    .last_redirect_out     (last_out),
`endif
    .misalign_err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fetch PC, queue of older PCs (front = youngest), number of
  // advances since the last flush/reset, and the error pulse.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  int          m_fill;
  logic        m_err;
  int          m_cnt;
  logic [31:0] m_last;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_pc = BOOT;
    m_q.delete();
    for (int k = 0; k < DEPTH; k++) m_q.push_back(32'h0);
    m_fill = 0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_last = BOOT;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_pc   = word_of(redir);
      m_fill = 0;
      m_err  = (redir % 4) != 0;
      m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_last = word_of(redir);
    end else if (stall) begin
      m_err = 1'b0;
    end else begin
      m_q.push_front(m_pc);
      void'(m_q.pop_back());
      m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
      m_err  = (pc_mux % 4) != 0;
      m_pc   = word_of(pc_mux);
    end
  endtask

  function automatic logic [XLEN*DEPTH-1:0] exp_pipe();
    logic [XLEN*DEPTH-1:0] v;
    for (int k = 0; k < DEPTH; k++) v[k*32 +: 32] = m_q[k];
    return v;
  endfunction

  function automatic logic [DEPTH-1:0] exp_valid();
    logic [DEPTH-1:0] v;
    for (int k = 0; k < DEPTH; k++) v[k] = (m_fill > k);
    return v;
  endfunction

  // Advance one clock, update the model with the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_mux = '0; stall = 1'b0; flush = 1'b0; redir = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_mux = $urandom;
      tick();
    end
    // Assert reset between edges; outputs must change with no clock edge.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (pc_out !== 32'h100) begin
      n_bad++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h100);
    end
    n_cmp++;
    if (valid_out !== 3'b000) begin
      n_bad++; $display("FAIL reset_valid: got %b want 000", valid_out);
    end
    n_cmp++;
    if (pipe_out !== '0 || err_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_pipe: got %h/%b want 0/0", pipe_out, err_out);
    end
  endtask

  task automatic test_advance();
    logic [31:0] seq[3];
    seq[0] = 32'h104; seq[1] = 32'h108; seq[2] = 32'h10C;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_mux = seq[i];
      tick();
      n_cmp++;
      if (pc_out !== m_pc || pipe_out !== exp_pipe() || valid_out !== exp_valid()) begin
        n_bad++;
        $display("FAIL advance_%0d: got pc=%h pipe=%h v=%b want pc=%h pipe=%h v=%b", i, pc_out,
                 pipe_out, valid_out, m_pc, exp_pipe(), exp_valid());
      end
    end
    n_cmp++;
    if (pipe_out !== {32'h100, 32'h104, 32'h108} || valid_out !== 3'b111 || pc_out !== 32'h10C)
    begin
      n_bad++;
      $display("FAIL advance_final: got pc=%h pipe=%h v=%b want pc=10c pipe=100/104/108 v=111",
               pc_out, pipe_out, valid_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0]           pc_before;
    logic [XLEN*DEPTH-1:0] pipe_before;
    logic [DEPTH-1:0]      v_before;
    pc_before = m_pc; pipe_before = exp_pipe(); v_before = exp_valid();
    pc_mux = 32'h200; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== pc_before || pipe_out !== pipe_before || valid_out !== v_before ||
          err_out !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got pc=%h pipe=%h v=%b e=%b want pc=%h pipe=%h v=%b e=0",
                 i, pc_out, pipe_out, valid_out, err_out, pc_before, pipe_before, v_before);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (pc_out !== 32'h200 || pipe_out !== exp_pipe()) begin
      n_bad++;
      $display("FAIL stall_release: got pc=%h pipe=%h want pc=200 pipe=%h", pc_out, pipe_out,
               exp_pipe());
    end
  endtask

  task automatic test_flush_beats_stall();
    logic [DEPTH-1:0] fill_seq[3];
    fill_seq[0] = 3'b001; fill_seq[1] = 3'b011; fill_seq[2] = 3'b111;
    stall = 1'b1; flush = 1'b1; redir = 32'h0000_0040;
    tick();
    n_cmp++;
    if (pc_out !== 32'h40 || valid_out !== 3'b000 || pipe_out !== exp_pipe()) begin
      n_bad++;
      $display("FAIL flush_over_stall: got pc=%h v=%b pipe=%h want pc=40 v=000 pipe=%h", pc_out,
               valid_out, pipe_out, exp_pipe());
    end
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_mux = 32'h44 + 32'(i * 4);
      tick();
      n_cmp++;
      if (valid_out !== fill_seq[i] || pipe_out[31:0] !== m_q[0]) begin
        n_bad++;
        $display("FAIL refill_%0d: got v=%b s0=%h want v=%b s0=%h", i, valid_out, pipe_out[31:0],
                 fill_seq[i], m_q[0]);
      end
    end
  endtask

  task automatic test_misalign();
    pc_mux = 32'hFFFF_FFFF;
    tick();
    n_cmp++;
    if (pc_out !== 32'hFFFF_FFFC || err_out !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_wrap: got pc=%h e=%b want pc=fffffffc e=1", pc_out, err_out);
    end
    pc_mux = 32'h0;
    tick();
    n_cmp++;
    if (pc_out !== 32'h0 || err_out !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_clear: got pc=%h e=%b want pc=0 e=0", pc_out, err_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      pc_mux = $urandom;
      redir  = $urandom;
      flush  = ($urandom_range(0, 7) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (pc_out !== m_pc || pipe_out !== exp_pipe() || valid_out !== exp_valid() ||
          err_out !== m_err) begin
        n_bad++;
        $display("FAIL random_%0d: got pc=%h pipe=%h v=%b e=%b want pc=%h pipe=%h v=%b e=%b", i,
                 pc_out, pipe_out, valid_out, err_out, m_pc, exp_pipe(), exp_valid(), m_err);
      end
    end
    flush = 1'b0; stall = 1'b0;
  endtask

`ifdef MSRV32_PC_TRACE_EN
  task automatic test_trace();
    logic [31:0] tgt[3];
    tgt[0] = 32'h10; tgt[1] = 32'h20; tgt[2] = 32'h33;
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redir = tgt[i];
      tick();
    end
    n_cmp++;
    if (cnt_out !== 16'd3 || last_out !== 32'h30) begin
      n_bad++;
      $display("FAIL trace_three: got cnt=%0d last=%h want cnt=3 last=30", cnt_out, last_out);
    end
    redir = 32'h80;
    for (int i = 0; i < 65540; i++) tick();
    n_cmp++;
    if (cnt_out !== 16'(m_cnt) || cnt_out !== 16'hFFFF || last_out !== m_last) begin
      n_bad++;
      $display("FAIL trace_saturate: got cnt=%h last=%h want cnt=ffff last=%h", cnt_out,
               last_out, m_last);
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_flush_beats_stall();
    test_misalign();
    test_random();
`ifdef MSRV32_PC_TRACE_EN
    test_trace();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
